// File: rtl/xg_ram_if.sv
// Port bundle for the xg_ram true dual-port RAM.
// The master drives address/data/write-enable and the slave returns the read data.
interface xg_ram_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic                  wren_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic [ADDR_WIDTH-1:0] address_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  wren_b;
    logic [DATA_WIDTH-1:0] q_b;

    modport master (
        output address_a, data_a, wren_a,
        output address_b, data_b, wren_b,
        input  q_a, q_b
    );

    modport slave (
        input  address_a, data_a, wren_a,
        input  address_b, data_b, wren_b,
        output q_a, q_b
    );
endinterface

// File: rtl/xg_ram.sv
// True dual-port synchronous RAM with registered read data on both ports.
// Same-port reads write through; cross-port reads see old data; port A wins collisions.
module xg_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic      clock,
    input  logic      rst,
    xg_ram_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] q_a_q = '0;
    logic [DATA_WIDTH-1:0] q_b_q = '0;
    logic [DATA_WIDTH-1:0] q_a_d;
    logic [DATA_WIDTH-1:0] q_b_d;

    // Reads use pre-edge contents, so the other port's write is not seen yet.
    always_comb begin
        q_a_d = mem_q[bus.address_a];
        q_b_d = mem_q[bus.address_b];
        if (bus.wren_a) begin
            q_a_d = bus.data_a;
        end
        if (bus.wren_b) begin
            q_b_d = bus.data_b;
        end
        if (rst) begin
            q_a_d = '0;
            q_b_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        q_a_q <= q_a_d;
        q_b_q <= q_b_d;
    end

    // Port A is written last so it wins a same-address collision.
    always_ff @(posedge clock) begin
        if (!rst) begin
            if (bus.wren_b) begin
                mem_q[bus.address_b] <= bus.data_b;
            end
            if (bus.wren_a) begin
                mem_q[bus.address_a] <= bus.data_a;
            end
        end
    end

    assign bus.q_a = q_a_q;
    assign bus.q_b = q_b_q;
endmodule

// File: tb/tb_xg_ram.sv
// Directed vector bench for xg_ram: table of single-cycle vectors,
// then a full-depth fill through port A with readback through port B.
module tb_xg_ram;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NV = 16;

    logic clock = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   failed = 0;

    xg_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    xg_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        string         name;
        logic          rst;
        logic [AW-1:0] addr_a;
        logic [DW-1:0] data_a;
        logic          wren_a;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] data_b;
        logic          wren_b;
        logic [DW-1:0] exp_qa;
        logic [DW-1:0] exp_qb;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r,
                         input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic wa,
                         input logic [AW-1:0] ab, input logic [DW-1:0] db,
                         input logic wb);
        rst           = r;
        bus.address_a = aa;
        bus.data_a    = da;
        bus.wren_a    = wa;
        bus.address_b = ab;
        bus.data_b    = db;
        bus.wren_b    = wb;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"reset",        1, 10'h000, 16'h0000, 0, 10'h000, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[1]  = '{"wr_a_3ff",     0, 10'h3FF, 16'hBEEF, 1, 10'h3FF, 16'h0000, 0, 16'hBEEF, 16'h0000};
        vecs[2]  = '{"rd_3ff",       0, 10'h3FF, 16'h0000, 0, 10'h3FF, 16'h0000, 0, 16'hBEEF, 16'hBEEF};
        vecs[3]  = '{"wr_a_rd_b",    0, 10'h010, 16'h1234, 1, 10'h010, 16'h0000, 0, 16'h1234, 16'h0000};
        vecs[4]  = '{"rd_b_010",     0, 10'h3FF, 16'h0000, 0, 10'h010, 16'h0000, 0, 16'hBEEF, 16'h1234};
        vecs[5]  = '{"wr_both_020",  0, 10'h020, 16'hAAAA, 1, 10'h020, 16'h5555, 1, 16'hAAAA, 16'h5555};
        vecs[6]  = '{"rd_020",       0, 10'h020, 16'h0000, 0, 10'h020, 16'h0000, 0, 16'hAAAA, 16'hAAAA};
        vecs[7]  = '{"wr_diff",      0, 10'h030, 16'h1111, 1, 10'h031, 16'h2222, 1, 16'h1111, 16'h2222};
        vecs[8]  = '{"rd_diff",      0, 10'h031, 16'h0000, 0, 10'h030, 16'h0000, 0, 16'h2222, 16'h1111};
        vecs[9]  = '{"wr_b_rd_a",    0, 10'h040, 16'h0000, 0, 10'h040, 16'hCAFE, 1, 16'h0000, 16'hCAFE};
        vecs[10] = '{"rd_a_040",     0, 10'h040, 16'h0000, 0, 10'h3FF, 16'h0000, 0, 16'hCAFE, 16'hBEEF};
        vecs[11] = '{"pre_rst",      0, 10'h3FF, 16'h0000, 0, 10'h000, 16'h0000, 0, 16'hBEEF, 16'h0000};
        vecs[12] = '{"rst_wr_supp",  1, 10'h3FF, 16'h0000, 1, 10'h040, 16'h0000, 1, 16'h0000, 16'h0000};
        vecs[13] = '{"post_rst",     0, 10'h3FF, 16'h0000, 0, 10'h040, 16'h0000, 0, 16'hBEEF, 16'hCAFE};
        vecs[14] = '{"wr_a_000",     0, 10'h000, 16'h0001, 1, 10'h000, 16'h0000, 0, 16'h0001, 16'h0000};
        vecs[15] = '{"rd_b_000",     0, 10'h3FF, 16'h0000, 0, 10'h000, 16'h0000, 0, 16'hBEEF, 16'h0001};

        bus.address_a = '0;
        bus.data_a    = '0;
        bus.wren_a    = 1'b0;
        bus.address_b = '0;
        bus.data_b    = '0;
        bus.wren_b    = 1'b0;
        #1;
        chk("init_qa", bus.q_a, 16'h0000);
        chk("init_qb", bus.q_b, 16'h0000);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].addr_a, vecs[i].data_a, vecs[i].wren_a,
                  vecs[i].addr_b, vecs[i].data_b, vecs[i].wren_b);
            chk({vecs[i].name, "_qa"}, bus.q_a, vecs[i].exp_qa);
            chk({vecs[i].name, "_qb"}, bus.q_b, vecs[i].exp_qb);
        end

        // q must hold between edges with inputs changed.
        bus.address_a = 10'h020;
        bus.address_b = 10'h020;
        #3;
        chk("hold_qa", bus.q_a, 16'hBEEF);
        chk("hold_qb", bus.q_b, 16'h0001);

        // Full-depth fill through A, readback through B.
        for (int i = 0; i < (1 << AW); i++) begin
            logic [DW-1:0] v;
            v = DW'(i) ^ 16'hA5A5;
            drive(1'b0, AW'(i), v, 1'b1, 10'h000, 16'h0000, 1'b0);
            chk($sformatf("fill_qa_%0h", i), bus.q_a, v);
        end
        for (int i = 0; i < (1 << AW); i++) begin
            logic [DW-1:0] v;
            v = DW'(i) ^ 16'hA5A5;
            drive(1'b0, 10'h000, 16'h0000, 1'b0, AW'(i), 16'h0000, 1'b0);
            chk($sformatf("rdback_qb_%0h", i), bus.q_b, v);
        end
        chk("fill_qa_0", bus.q_a, 16'hA5A5);
        drive(1'b0, 10'h3FF, 16'h0000, 1'b0, 10'h000, 16'h0000, 1'b0);
        chk("fill_end_qa", bus.q_a, 16'hA65A);
        chk("fill_end_qb", bus.q_b, 16'hA5A5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/xg_ram.md
XG_RAM -- requirements
Module: xg_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word address width per port (depth = 2^ADDR_WIDTH = 1024 words).
REQ-002 Parameter DATA_WIDTH, default 16, word width.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 address_a  input  ADDR_WIDTH  port A word address.
REQ-006 data_a  input  DATA_WIDTH  port A write data.
REQ-007 wren_a  input  1  port A write enable.
REQ-008 q_a  output  DATA_WIDTH  port A registered read data.
REQ-009 address_b  input  ADDR_WIDTH  port B word address.
REQ-010 data_b  input  DATA_WIDTH  port B write data.
REQ-011 wren_b  input  1  port B write enable.
REQ-012 q_b  output  DATA_WIDTH  port B registered read data.

Function
REQ-013 The block SHALL be a true dual-port synchronous RAM: one shared storage array of 2^ADDR_WIDTH x DATA_WIDTH, two independent read/write ports on the same clock.
REQ-014 Write: when wren_x=1 at a rising edge (rst=0), mem[address_x] SHALL take data_x at that edge.
REQ-015 Read: at every rising edge (rst=0), q_x SHALL load the contents of mem[address_x]; read latency is exactly 1 cycle from address presentation; q_x holds between edges.
REQ-016 Reads SHALL occur every cycle regardless of wren (no read enable); address and data inputs are sampled only at the edge.
REQ-017 Same-port read-during-write: when wren_x=1, q_x SHALL show data_x (new data, write-through) after that edge.
REQ-018 Mixed-port read-during-write: when port X writes address N and port Y reads N in the same cycle, q_y SHALL show the old contents of N; the new value is visible on port Y from the next read.
REQ-019 Simultaneous writes to the same address from both ports SHALL leave mem[N] = data_a (port A wins); each port's q follows REQ-017 for its own data.
REQ-020 Simultaneous writes to different addresses SHALL both complete.
REQ-021 All addresses 0..2^ADDR_WIDTH-1 SHALL be valid; no wrap or aliasing; no other address decoding.
REQ-022 Initial contents (power-up/simulation start) SHALL be all zeros; q_a, q_b SHALL initialise to 0.
REQ-023 No combinational path from any input to q_a/q_b.

Reset
REQ-024 While rst=1 at a rising edge, q_a and q_b SHALL be set to 0.
REQ-025 While rst=1, writes on both ports SHALL be suppressed; stored array contents SHALL be otherwise preserved (reset does not clear memory).
REQ-026 Reset asserted mid-operation SHALL take effect at the next edge only; the first edge with rst=0 SHALL perform normal read/write per REQ-014..REQ-019.

Verification
REQ-027 Write A addr 0x3FF = 0xBEEF, next cycle read A addr 0x3FF -> q_a = 0xBEEF one cycle after address applied; read B addr 0x3FF -> q_b = 0xBEEF.
REQ-028 Write A addr 0x010 = 0x1234 while B reads 0x010 same cycle (prior value 0x0000) -> q_a = 0x1234, q_b = 0x0000; next cycle q_b = 0x1234.
REQ-029 Both ports write addr 0x020 (A=0xAAAA, B=0x5555) -> subsequent reads of 0x020 on both ports return 0xAAAA.
REQ-030 Fill all 1024 words via port A with value = address ^ 0xA5A5, read back via port B -> every word matches, including 0x000 and 0x3FF.
REQ-031 With q_a = 0xBEEF, assert rst one cycle with wren_a=1 addr 0x3FF data 0x0000 -> q_a = q_b = 0; after release, read 0x3FF -> 0xBEEF (write suppressed, contents kept).
